mdio_phy_ctrl: RTL and testbench

- Clause-22 MDIO management master for the N210 TruPHY ET1011 GMII PHY.
- Owns the PHY hardware reset (`gmii_rstn`) and its power-up sequencing.
- Serializes single read/write requests from a control-plane requester into MDC/MDIO frames and returns read data with an error flag.
- Sits between the platform control logic and the top-level `mdio_mdc`/`mdio_mdd` pins. The tristate buffer is at top level: this block exposes `mdd_o`, `mdd_oe` and `mdd_i`.

---
 rtl/mdio_phy_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_mdio_phy_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_phy_ctrl.sv
// Clause-22 MDIO management master with PHY hardware-reset sequencing.
// One request at a time: accept, shift a 64-bit MDC/MDIO frame, return a response.
module mdio_phy_ctrl #(
   parameter int unsigned CLK_DIV    = 2,
   parameter int unsigned RST_HOLD   = 16,
   parameter int unsigned RST_SETTLE = 32
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [4:0]  req_phy,
   input  logic [4:0]  req_reg,
   input  logic [15:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_rdata,
   output logic        rsp_err,
   output logic        gmii_rstn,
   output logic        mdio_mdc,
   output logic        mdd_o,
   output logic        mdd_oe,
   input  logic        mdd_i
);

   localparam int unsigned CntMax = (RST_HOLD > RST_SETTLE) ? RST_HOLD : RST_SETTLE;
   localparam int unsigned CntW   = $clog2(CntMax + 1);
   localparam int unsigned DivW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

   typedef enum logic [2:0] {StPhyRst, StSettle, StIdle, StShift, StResp} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [DivW-1:0]   div_q, div_d;
   logic              half_q, half_d;
   logic [5:0]        bit_q, bit_d;
   logic              write_q, write_d;
   logic [4:0]        phy_q, phy_d;
   logic [4:0]        reg_q, reg_d;
   logic [15:0]       wdata_q, wdata_d;
   logic              req_ready_q, req_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [15:0]       rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              gmii_rstn_q, gmii_rstn_d;
   logic              mdc_q, mdc_d;
   logic              mdd_o_q, mdd_o_d;
   logic              mdd_oe_q, mdd_oe_d;
   logic [63:0]       frame_w;

   assign frame_w = {32'hFFFF_FFFF, 2'b01, (write_q ? 2'b01 : 2'b10), phy_q, reg_q, 2'b10,
                     wdata_q};

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      div_d       = div_q;
      half_d      = half_q;
      bit_d       = bit_q;
      write_d     = write_q;
      phy_d       = phy_q;
      reg_d       = reg_q;
      wdata_d     = wdata_q;
      req_ready_d = 1'b0;
      rsp_valid_d = 1'b0;
      rdata_d     = rdata_q;
      err_d       = err_q;
      gmii_rstn_d = gmii_rstn_q;
      mdc_d       = 1'b0;
      mdd_o_d     = 1'b1;
      mdd_oe_d    = 1'b0;
      unique case (state_q)
         StPhyRst: begin
            if (cnt_q == CntW'(RST_HOLD - 1)) begin
               cnt_d       = '0;
               gmii_rstn_d = 1'b1;
               state_d     = StSettle;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StSettle: begin
            if (cnt_q == CntW'(RST_SETTLE - 1)) begin
               cnt_d       = '0;
               req_ready_d = 1'b1;
               state_d     = StIdle;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StIdle: begin
            if (req_valid && req_ready_q) begin
               write_d = req_write;
               phy_d   = req_phy;
               reg_d   = req_reg;
               wdata_d = req_wdata;
               rdata_d = '0;
               err_d   = 1'b0;
               div_d   = '0;
               half_d  = 1'b0;
               bit_d   = '0;
               state_d = StShift;
            end else begin
               req_ready_d = 1'b1;
            end
         end
         StShift: begin
            // Outputs are registered, so they trail the bit counters by one cycle.
            mdc_d    = half_q;
            mdd_o_d  = frame_w[6'd63 - bit_q];
            mdd_oe_d = write_q || (bit_q < 6'd46);
            if (half_q && (div_q == '0) && !write_q) begin
               if (bit_q == 6'd47) begin
                  err_d = mdd_i;
               end else if (bit_q >= 6'd48) begin
                  rdata_d = {rdata_q[14:0], mdd_i};
               end
            end
            if (div_q == DivW'(CLK_DIV - 1)) begin
               div_d = '0;
               if (half_q) begin
                  half_d = 1'b0;
                  if (bit_q == 6'd63) begin
                     state_d = StResp;
                  end else begin
                     bit_d = bit_q + 1'b1;
                  end
               end else begin
                  half_d = 1'b1;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         StResp: begin
            if (rsp_valid_q && rsp_ready) begin
               req_ready_d = 1'b1;
               state_d     = StIdle;
            end else begin
               rsp_valid_d = 1'b1;
            end
         end
         default: state_d = StPhyRst;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= StPhyRst;
         cnt_q       <= '0;
         div_q       <= '0;
         half_q      <= 1'b0;
         bit_q       <= '0;
         write_q     <= 1'b0;
         phy_q       <= '0;
         reg_q       <= '0;
         wdata_q     <= '0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         gmii_rstn_q <= 1'b0;
         mdc_q       <= 1'b0;
         mdd_o_q     <= 1'b1;
         mdd_oe_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         div_q       <= div_d;
         half_q      <= half_d;
         bit_q       <= bit_d;
         write_q     <= write_d;
         phy_q       <= phy_d;
         reg_q       <= reg_d;
         wdata_q     <= wdata_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         gmii_rstn_q <= gmii_rstn_d;
         mdc_q       <= mdc_d;
         mdd_o_q     <= mdd_o_d;
         mdd_oe_q    <= mdd_oe_d;
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   assign gmii_rstn = gmii_rstn_q;
   assign mdio_mdc  = mdc_q;
   assign mdd_o     = mdd_o_q;
   assign mdd_oe    = mdd_oe_q;

endmodule

// File: tb/tb_mdio_phy_ctrl.sv
// Directed bench for mdio_phy_ctrl: power-up timing, write/read frames, backpressure,
// and asynchronous reset in the middle of a frame.
module tb_mdio_phy_ctrl;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [4:0]  req_phy = '0;
   logic [4:0]  req_reg = '0;
   logic [15:0] req_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [15:0] rsp_rdata;
   logic        rsp_err;
   logic        gmii_rstn;
   logic        mdio_mdc;
   logic        mdd_o;
   logic        mdd_oe;
   logic        mdd_i = 1'b1;

   int n_checks = 0;
   int n_errors = 0;

   // PHY model and frame monitor
   int          mon_n = 0;
   int          mon_base = 0;
   logic [63:0] mon_word = '0;
   logic [63:0] mon_oew = '0;
   logic        phy_en = 1'b0;
   logic [15:0] phy_data = '0;

   mdio_phy_ctrl dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_phy   (req_phy),
      .req_reg   (req_reg),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .gmii_rstn (gmii_rstn),
      .mdio_mdc  (mdio_mdc),
      .mdd_o     (mdd_o),
      .mdd_oe    (mdd_oe),
      .mdd_i     (mdd_i)
   );

   always #5 CLK = ~CLK;

   // On each MDC rise, log the driven bit and present the PHY's value for the next bit.
   always @(posedge mdio_mdc) begin
      int k;
      mon_word = {mon_word[62:0], mdd_o};
      mon_oew  = {mon_oew[62:0], mdd_oe};
      mon_n    = mon_n + 1;
      k        = mon_n - mon_base;
      if (phy_en && k == 47) mdd_i = 1'b0;
      else if (phy_en && k >= 48 && k <= 63) mdd_i = phy_data[63 - k];
      else mdd_i = 1'b1;
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic powerup_check(input string tag);
      int gm_rise = -1;
      int rdy_first = -1;
      int mdc_bad = 0;
      @(negedge CLK);
      RST_N = 1'b1;
      for (int n = 1; n <= 60; n++) begin
         @(posedge CLK);
         #1;
         if (gmii_rstn && gm_rise < 0) gm_rise = n;
         if (req_ready && rdy_first < 0) rdy_first = n;
         if (mdio_mdc) mdc_bad++;
      end
      check_eq({tag, "_gmii_rise"}, 64'(gm_rise), 64'd16);
      check_eq({tag, "_ready_first"}, 64'(rdy_first), 64'd48);
      check_eq({tag, "_mdc_idle"}, 64'(mdc_bad), 64'd0);
   endtask

   task automatic issue(input logic w, input logic [4:0] phy, input logic [4:0] rg,
                        input logic [15:0] wd);
      int tries = 0;
      @(negedge CLK);
      while (!req_ready && tries < 500) begin
         @(negedge CLK);
         tries++;
      end
      check_eq("req_ready_seen", 64'(req_ready), 64'd1);
      req_write = w;
      req_phy   = phy;
      req_reg   = rg;
      req_wdata = wd;
      req_valid = 1'b1;
      mon_base  = mon_n;
      @(posedge CLK);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      while (!rsp_valid && lat < 2000) begin
         @(posedge CLK);
         #1;
         lat++;
      end
   endtask

   task automatic consume(input string tag);
      @(negedge CLK);
      rsp_ready = 1'b1;
      @(posedge CLK);
      #1;
      rsp_ready = 1'b0;
      check_eq({tag, "_rsp_dropped"}, 64'(rsp_valid), 64'd0);
      check_eq({tag, "_ready_back"}, 64'(req_ready), 64'd1);
   endtask

   initial begin
      int lat;
      int bad;
      int seen_rsp;
      logic [15:0] hold_data;

      // Reset values
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check_eq("rst_gmii_rstn", 64'(gmii_rstn), 64'd0);
      check_eq("rst_mdc", 64'(mdio_mdc), 64'd0);
      check_eq("rst_mdd_o", 64'(mdd_o), 64'd1);
      check_eq("rst_mdd_oe", 64'(mdd_oe), 64'd0);
      check_eq("rst_req_ready", 64'(req_ready), 64'd0);
      check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check_eq("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
      check_eq("rst_rsp_err", 64'(rsp_err), 64'd0);

      powerup_check("pwr1");

      // Write phy=1 reg=0 data=0x1140
      issue(1'b1, 5'h01, 5'h00, 16'h1140);
      wait_rsp(lat);
      check_eq("wr_latency", 64'(lat), 64'd257);
      check_eq("wr_bits", 64'(mon_n - mon_base), 64'd64);
      check_eq("wr_frame", mon_word, 64'hFFFF_FFFF_5082_1140);
      check_eq("wr_oe", mon_oew, 64'hFFFF_FFFF_FFFF_FFFF);
      check_eq("wr_rdata", 64'(rsp_rdata), 64'd0);
      check_eq("wr_err", 64'(rsp_err), 64'd0);
      check_eq("wr_no_ready", 64'(req_ready), 64'd0);
      check_eq("wr_end_mdc", 64'(mdio_mdc), 64'd0);
      check_eq("wr_end_oe", 64'(mdd_oe), 64'd0);
      consume("wr");

      // Read phy=1 reg=2 from a PHY answering 0x0282
      phy_en   = 1'b1;
      phy_data = 16'h0282;
      issue(1'b0, 5'h01, 5'h02, 16'h0000);
      wait_rsp(lat);
      check_eq("rd_latency", 64'(lat), 64'd257);
      check_eq("rd_oe", mon_oew, 64'hFFFF_FFFF_FFFC_0000);
      check_eq("rd_hdr", mon_word & 64'hFFFF_FFFF_FFFC_0000, 64'hFFFF_FFFF_6088_0000);
      check_eq("rd_rdata", 64'(rsp_rdata), 64'h0282);
      check_eq("rd_err", 64'(rsp_err), 64'd0);
      consume("rd");

      // Read with nobody answering
      phy_en = 1'b0;
      issue(1'b0, 5'h05, 5'h01, 16'h0000);
      wait_rsp(lat);
      check_eq("nophy_latency", 64'(lat), 64'd257);
      check_eq("nophy_rdata", 64'(rsp_rdata), 64'hFFFF);
      check_eq("nophy_err", 64'(rsp_err), 64'd1);

      // Backpressure with a second request pending
      @(negedge CLK);
      req_write = 1'b1;
      req_phy   = 5'h03;
      req_reg   = 5'h04;
      req_wdata = 16'hA5A5;
      req_valid = 1'b1;
      hold_data = rsp_rdata;
      bad = 0;
      for (int n = 0; n < 50; n++) begin
         @(negedge CLK);
         if (!rsp_valid || rsp_rdata !== hold_data || !rsp_err || req_ready || mdio_mdc)
            bad++;
      end
      check_eq("bp_stable", 64'(bad), 64'd0);
      rsp_ready = 1'b1;
      mon_base  = mon_n;
      @(posedge CLK);
      #1;
      rsp_ready = 1'b0;
      check_eq("bp_resp_done", 64'(rsp_valid), 64'd0);
      check_eq("bp_idle_ready", 64'(req_ready), 64'd1);
      @(posedge CLK);
      #1;
      req_valid = 1'b0;
      check_eq("bp_accepted", 64'(req_ready), 64'd0);
      wait_rsp(lat);
      check_eq("bp_latency", 64'(lat), 64'd257);
      check_eq("bp_frame", mon_word, 64'hFFFF_FFFF_5192_A5A5);
      check_eq("bp_rdata", 64'(rsp_rdata), 64'd0);
      consume("bp");

      // Asynchronous reset during bit 40 of a write
      issue(1'b1, 5'h01, 5'h00, 16'h1140);
      lat = 0;
      seen_rsp = 0;
      while ((mon_n - mon_base) < 41 && lat < 500) begin
         @(posedge CLK);
         #1;
         lat++;
         if (rsp_valid) seen_rsp++;
      end
      check_eq("mid_reached_bit40", 64'(mon_n - mon_base), 64'd41);
      #2;
      RST_N = 1'b0;
      #1;
      check_eq("mid_oe", 64'(mdd_oe), 64'd0);
      check_eq("mid_mdc", 64'(mdio_mdc), 64'd0);
      check_eq("mid_gmii", 64'(gmii_rstn), 64'd0);
      repeat (3) begin
         @(posedge CLK);
         #1;
         if (rsp_valid) seen_rsp++;
      end
      powerup_check("pwr2");
      repeat (300) begin
         @(posedge CLK);
         #1;
         if (rsp_valid) seen_rsp++;
      end
      check_eq("mid_no_rsp", 64'(seen_rsp), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
